// File: rtl/cdc_lib_pkg.sv
// Shared CDC helpers: minimum-1 counter width function and reset-level constants.
package cdc_lib_pkg;

  localparam logic RESET_LOW  = 1'b0;
  localparam logic RESET_HIGH = 1'b1;

  // $clog2 returns 0 for 1, which would give a zero-width counter.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: stability filter counter, filtered level and registered edge pulses.
// Filter enabled only when SYNCHRONIZER_FILTERED_GLITCH_EN is defined.
module sync_filter_ch
  import cdc_lib_pkg::*;
#(
  parameter int P_FILTER_CNT = 4,
  parameter int P_RESET_VAL  = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_synced,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_changing
);

  localparam logic RST_BIT = (P_RESET_VAL == 0) ? RESET_LOW : RESET_HIGH;

  if (P_FILTER_CNT < 1) begin : g_param_err
    $error("[COMPILE-ERROR] sync_filter_ch: P_FILTER_CNT must be >= 1");
  end

  logic q_q, q_d;
  logic rise_q, fall_q;

`ifdef SYNCHRONIZER_FILTERED_GLITCH_EN
  localparam int unsigned CW = clog2_min1(P_FILTER_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_FILTER_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample equal to the current level restarts the count.
  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (i_synced != q_q) begin
      if (cnt_q == CNT_LAST) begin
        q_d = i_synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_changing = |cnt_q;
`else
  always_comb begin
    q_d = i_synced;
  end

  assign o_changing = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_q    <= RST_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign o_q    = q_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/synchronizer_filtered.sv
// Multi-channel level synchronizer with per-channel glitch filter and edge detect.
// Glitch filter enabled by defining SYNCHRONIZER_FILTERED_GLITCH_EN.
module synchronizer_filtered
  import cdc_lib_pkg::*;
#(
  parameter int P_CHANNELS   = 1,
  parameter int P_DEPTH      = 2,
  parameter int P_FILTER_CNT = 4,
  parameter int P_RESET_VAL  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_CHANNELS-1:0] i_d,
  output logic [P_CHANNELS-1:0] o_q,
  output logic [P_CHANNELS-1:0] o_rise,
  output logic [P_CHANNELS-1:0] o_fall,
  output logic [P_CHANNELS-1:0] o_changing
);

  localparam logic RST_BIT = (P_RESET_VAL == 0) ? RESET_LOW : RESET_HIGH;

  if (P_DEPTH < 2 || P_CHANNELS < 1 || (P_RESET_VAL != 0 && P_RESET_VAL != 1))
  begin : g_param_err
    $error("[COMPILE-ERROR] synchronizer_filtered: need P_DEPTH>=2, P_CHANNELS>=1, P_RESET_VAL in {0,1}");
  end

  // Stage-major packing keeps each stage's flops together for placement constraints.
  logic [P_DEPTH-1:0][P_CHANNELS-1:0] sync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {P_DEPTH{{P_CHANNELS{RST_BIT}}}};
    end else begin
      sync_q <= {sync_q[P_DEPTH-2:0], i_d};
    end
  end

  for (genvar c = 0; c < P_CHANNELS; c++) begin : g_ch
    sync_filter_ch #(
      .P_FILTER_CNT (P_FILTER_CNT),
      .P_RESET_VAL  (P_RESET_VAL)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_synced   (sync_q[P_DEPTH-1][c]),
      .o_q        (o_q[c]),
      .o_rise     (o_rise[c]),
      .o_fall     (o_fall[c]),
      .o_changing (o_changing[c])
    );
  end

endmodule

// File: tb/tb_synchronizer_filtered.sv
// Directed bench for synchronizer_filtered; expectations follow SYNCHRONIZER_FILTERED_GLITCH_EN.
module tb_synchronizer_filtered;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst1 = 1'b1;
  logic [3:0] d = '0;
  logic [3:0] d1 = '1;
  logic [3:0] q, rise, fall, chg;
  logic [3:0] q1, rise1, fall1, chg1;

  int checks = 0;
  int failures = 0;

`ifdef SYNCHRONIZER_FILTERED_GLITCH_EN
  localparam bit FILT = 1'b1;
  localparam int STEP_LAT = 6;
`else
  localparam bit FILT = 1'b0;
  localparam int STEP_LAT = 3;
`endif

  synchronizer_filtered #(
    .P_CHANNELS(4), .P_DEPTH(2), .P_FILTER_CNT(4), .P_RESET_VAL(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_d(d),
    .o_q(q), .o_rise(rise), .o_fall(fall), .o_changing(chg)
  );

  synchronizer_filtered #(
    .P_CHANNELS(4), .P_DEPTH(2), .P_FILTER_CNT(4), .P_RESET_VAL(1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_d(d1),
    .o_q(q1), .o_rise(rise1), .o_fall(fall1), .o_changing(chg1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] chg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] vd, vq, vr, vf, vc);
    vec_t v;
    v.d = vd; v.q = vq; v.rise = vr; v.fall = vf; v.chg = vc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // One entry per clock edge: 1010 step up/down, then a 3-cycle glitch on bit 0.
    if (FILT) begin
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'hA);
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'hA);
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'hA);
      add(4'hA, 4'hA, 4'hA, 4'h0, 4'h0);
      add(4'hA, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'hA);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'hA);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'hA);
      add(4'h0, 4'h0, 4'h0, 4'hA, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end else begin
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'hA, 4'hA, 4'h0, 4'h0);
      add(4'hA, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'hA, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'hA, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'hA, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
      add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
      add(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Reset state
    repeat (2) tick();
    chk("rst_q", q, 4'h0);
    chk("rst_rise", rise, 4'h0);
    chk("rst_fall", fall, 4'h0);
    chk("rst_chg", chg, 4'h0);
    chk("rst1_q", q1, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    rst1 = 1'b0;
    tick();
    chk("rel_q", q, 4'h0);
    chk("rel_rise", rise, 4'h0);
    chk("rel1_rise", rise1, 4'h0);
    chk("rel1_fall", fall1, 4'h0);

    // Table: simultaneous edges and glitch rejection
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      d = tbl[i].d;
      tick();
      chk($sformatf("v%0d_q", i), q, tbl[i].q);
      chk($sformatf("v%0d_rise", i), rise, tbl[i].rise);
      chk($sformatf("v%0d_fall", i), fall, tbl[i].fall);
      chk($sformatf("v%0d_chg", i), chg, tbl[i].chg);
      chk($sformatf("v%0d_excl", i), rise & fall, 4'h0);
    end

    // Step on bit 2: latency counted in rising edges
    @(negedge clk);
    d = 4'h4;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (q[2]) begin
        n = k;
        break;
      end
    end
    chk_int("step_latency", n, STEP_LAT);
    chk("step_rise", rise, 4'h4);
    chk("step_q", q, 4'h4);
    tick();
    chk("step_rise_end", rise, 4'h0);
    chk("step_q_hold", q, 4'h4);
    @(negedge clk);
    d = 4'h0;
    repeat (10) tick();
    chk("step_q_back", q, 4'h0);

    // Reset with a change pending (cnt=2 when filtered)
    @(negedge clk);
    d = 4'h2;
    repeat (4) tick();
    chk("mid_chg", chg, FILT ? 4'h2 : 4'h0);
    chk("mid_q", q, FILT ? 4'h0 : 4'h2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_q", q, 4'h0);
    chk("mid_rst_chg", chg, 4'h0);
    chk("mid_rst_rise", rise, 4'h0);
    chk("mid_rst_fall", fall, 4'h0);
    @(negedge clk);
    d = 4'h0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("mid_rel_q", q, 4'h0);
      chk("mid_rel_pulse", rise | fall, 4'h0);
    end

    // Reset value 1: drive low, then async reset mid-cycle
    chk("r1_q_idle", q1, 4'hF);
    @(negedge clk);
    d1 = 4'h0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (q1 == 4'h0) begin
        n = k;
        break;
      end
    end
    chk_int("r1_fall_latency", n, STEP_LAT);
    chk("r1_fall", fall1, 4'hF);
    @(posedge clk);
    #3 rst1 = 1'b1;
    #1;
    chk("r1_rst_q", q1, 4'hF);
    chk("r1_rst_rise", rise1, 4'h0);
    chk("r1_rst_fall", fall1, 4'h0);
    chk("r1_rst_chg", chg1, 4'h0);
    @(negedge clk);
    d1 = 4'hF;
    tick();
    @(negedge clk);
    rst1 = 1'b0;
    repeat (4) begin
      tick();
      chk("r1_rel_q", q1, 4'hF);
      chk("r1_rel_pulse", rise1 | fall1, 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
